// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// ALUControl codes and the field values used by the datapath selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Map the data-processing cmd field onto the ALU operation; unsupported
  // commands fall back to ADD.
  function automatic logic [1:0] alu_code(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_code = ALU_ADD;
      4'b0010: alu_code = ALU_SUB;
      4'b0000: alu_code = ALU_AND;
      4'b1100: alu_code = ALU_ORR;
      default: alu_code = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_dec.sv
// State-independent decode: ALU operation, flag-write enables, PC-write
// select and the immediate / register-source selects.
module ctrl_dec
  import ctrl_pkg::*;
(
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       alu_op,
  input  logic       branch,
  input  logic       reg_w,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  // ALU operation and flag-write enables; NZ follow S, CV only for add/sub
  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = '0;
    if (alu_op) begin
      ALUControl = alu_code(Funct[4:1]);
      FlagW[1]   = Funct[0];
      FlagW[0]   = Funct[0] & ((ALUControl == ALU_ADD) || (ALUControl == ALU_SUB));
    end
  end

  assign PCS    = ((Rd == 4'hF) & reg_w) | branch;
  assign ImmSrc = Op;
  assign RegSrc = {(Op == OP_MEM), (Op == OP_BR)};

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: Moore FSM sequencing fetch / decode / execute /
// writeback, with the state-independent decode in ctrl_dec.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  state_t state, state_next;

  logic ir_write, next_pc, reg_w, mem_w, alu_op, branch;

  // State register; reset forces FETCH without waiting for a clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state selection and per-state Moore outputs
  always_comb begin
    state_next = S_FETCH;
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_op     = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        state_next = S_DECODE;
        ir_write   = 1'b1;
        next_pc    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALU;
      end
      S_DECODE: begin
        case (Op)
          OP_DP:   state_next = Funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_next = S_MEMADR;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_UNKNOWN;
        endcase
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_MEMADR: begin
        state_next = Funct[0] ? S_MEMRD : S_MEMWR;
        ALUSrcB    = SRCB_IMM;
      end
      S_MEMRD: begin
        state_next = S_MEMWB;
        AdrSrc     = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR: begin
        state_next = S_ALUWB;
        alu_op     = 1'b1;
      end
      S_EXECI: begin
        state_next = S_ALUWB;
        ALUSrcB    = SRCB_IMM;
        alu_op     = 1'b1;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        branch    = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // While reset is held the FSM already sits in FETCH; only the strobes
  // need masking so nothing is written before the first real cycle.
  assign IRWrite = ir_write & reset;
  assign NextPC  = next_pc & reset;
  assign RegW    = reg_w & reset;
  assign MemW    = mem_w & reset;

  ctrl_dec u_dec (
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .alu_op     (alu_op & reset),
    .branch     (branch & reset),
    .reg_w      (reg_w & reset),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: every cycle of each instruction
// is compared against a model indexed by instruction class and cycle number.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       pcs;
    logic [1:0] flag_w;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
  } out_t;

  int unsigned errors = 0;
  int unsigned checks = 0;
  out_t got, exp;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .NextPC     (NextPC),
    .RegW       (RegW),
    .MemW       (MemW),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ResultSrc  (ResultSrc),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  // Cycles per instruction: B / illegal 3, DP / STR 4, LDR 5
  function automatic int unsigned instr_len(input logic [1:0] op, input logic [5:0] fn);
    if (op[1])              return 3;
    if (op == 2'b01 && fn[0]) return 5;
    return 4;
  endfunction

  // Expected outputs on cycle k (0 = fetch) of the instruction op/fn/rd
  function automatic out_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [3:0] rd, input int unsigned k);
    out_t o;
    int   cmd;
    o         = '0;
    o.imm_src = op;
    o.reg_src = {op == 2'b01, op == 2'b10};
    if (k == 0) begin
      o.ir_write = 1; o.next_pc = 1; o.alu_src_a = 1; o.alu_src_b = 2; o.result_src = 2;
    end else if (k == 1) begin
      o.alu_src_a = 1; o.alu_src_b = 2; o.result_src = 2;
    end else if (op == 2'b00) begin
      if (k == 2) begin
        o.alu_src_b = fn[5] ? 2'd1 : 2'd0;
        cmd = int'(fn[4:1]);
        o.alu_control = (cmd == 2) ? 2'd1 : (cmd == 0) ? 2'd2 : (cmd == 12) ? 2'd3 : 2'd0;
        o.flag_w = {fn[0], fn[0] & (o.alu_control < 2)};
      end else begin
        o.reg_w = 1; o.pcs = (rd == 15);
      end
    end else if (op == 2'b01) begin
      if (k == 2)      o.alu_src_b = 1;
      else if (k == 3) begin o.adr_src = 1; o.mem_w = !fn[0]; end
      else begin o.result_src = 1; o.reg_w = 1; o.pcs = (rd == 15); end
    end else if (op == 2'b10) begin
      o.alu_src_b = 1; o.result_src = 2; o.pcs = 1;
    end
    return o;
  endfunction

  // While reset is low: fetch selects, but no strobes
  function automatic out_t reset_model(input logic [1:0] op);
    out_t o;
    o = model(op, 6'd0, 4'd0, 0);
    o.ir_write = 0; o.next_pc = 0;
    return o;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.ir_write = IRWrite;   o.next_pc = NextPC;     o.adr_src = AdrSrc;
    o.alu_src_a = ALUSrcA;  o.alu_src_b = ALUSrcB;  o.result_src = ResultSrc;
    o.reg_w = RegW;         o.mem_w = MemW;         o.pcs = PCS;
    o.flag_w = FlagW;       o.alu_control = ALUControl;
    o.imm_src = ImmSrc;     o.reg_src = RegSrc;
    return o;
  endfunction

  task automatic test_reset();
    reset = 1'b0; Op = 2'b10; Funct = 6'h3F; Rd = 4'hF;
    #3;
    got = observe(); exp = reset_model(Op); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got, exp); end
    @(negedge clk); reset = 1'b1; #1;
    got = observe(); exp = model(Op, Funct, Rd, 0); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_release got=%h exp=%h", got, exp); end
    @(posedge clk); #1;
    got = observe(); exp = model(Op, Funct, Rd, 1); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_decode got=%h exp=%h", got, exp); end
    for (int unsigned k = 2; k < 3; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_flags();
    Op = 2'b00; Funct = 6'b001001; Rd = 4'd3; #1;
    for (int unsigned k = 0; k < instr_len(Op, Funct); k++) begin
      got = observe(); exp = model(Op, Funct, Rd, k); checks++;
      if (got !== exp) begin errors++; $display("FAIL add_s k=%0d got=%h exp=%h", k, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ldr();
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd7; #1;
    for (int unsigned k = 0; k < instr_len(Op, Funct); k++) begin
      got = observe(); exp = model(Op, Funct, Rd, k); checks++;
      if (got !== exp) begin errors++; $display("FAIL ldr k=%0d got=%h exp=%h", k, got, exp); end
      @(posedge clk); #1;
    end
    got = observe(); exp = model(2'b01, 6'd0, 4'd0, 0); checks++;
    if (got !== exp) begin errors++; $display("FAIL ldr_refetch got=%h exp=%h", got, exp); end
  endtask

  task automatic test_str();
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd2; #1;
    for (int unsigned k = 0; k < instr_len(Op, Funct); k++) begin
      got = observe(); exp = model(Op, Funct, Rd, k); checks++;
      if (got !== exp) begin errors++; $display("FAIL str k=%0d got=%h exp=%h", k, got, exp); end
      @(posedge clk); #1;
    end
    got = observe(); exp = model(Op, Funct, Rd, 0); checks++;
    if (got !== exp) begin errors++; $display("FAIL str_refetch got=%h exp=%h", got, exp); end
  endtask

  task automatic test_branch_pcs();
    Op = 2'b10; Funct = 6'($urandom); Rd = 4'($urandom); #1;
    for (int unsigned k = 0; k < instr_len(Op, Funct); k++) begin
      got = observe(); exp = model(Op, Funct, Rd, k); checks++;
      if (got !== exp) begin errors++; $display("FAIL branch k=%0d got=%h exp=%h", k, got, exp); end
      @(posedge clk); #1;
    end
    Op = 2'b00; Funct = 6'b101000; Rd = 4'hF; #1;
    for (int unsigned k = 0; k < instr_len(Op, Funct); k++) begin
      got = observe(); exp = model(Op, Funct, Rd, k); checks++;
      if (got !== exp) begin errors++; $display("FAIL dp_rd15 k=%0d got=%h exp=%h", k, got, exp); end
      @(posedge clk); #1;
    end
    Op = 2'b11; Funct = 6'($urandom); Rd = 4'hF; #1;
    for (int unsigned k = 0; k < instr_len(Op, Funct); k++) begin
      got = observe(); exp = model(Op, Funct, Rd, k); checks++;
      if (got !== exp) begin errors++; $display("FAIL illegal k=%0d got=%h exp=%h", k, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops();
    for (int unsigned c = 0; c < 16; c++) begin
      for (int unsigned s = 0; s < 2; s++) begin
        Op = 2'b00; Rd = 4'($urandom_range(0, 14));
        Funct = {1'($urandom), 4'(c), 1'(s)}; #1;
        for (int unsigned k = 0; k < instr_len(Op, Funct); k++) begin
          got = observe(); exp = model(Op, Funct, Rd, k); checks++;
          if (got !== exp) begin
            errors++; $display("FAIL alu_cmd%0d_s%0d k=%0d got=%h exp=%h", c, s, k, got, exp);
          end
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic test_reset_mid_instr();
    Op = 2'b01; Funct = 6'b000001; Rd = 4'd9; #1;
    for (int unsigned k = 0; k < 4; k++) begin
      got = observe(); exp = model(Op, Funct, Rd, k); checks++;
      if (got !== exp) begin errors++; $display("FAIL mid_pre k=%0d got=%h exp=%h", k, got, exp); end
      if (k < 3) begin @(posedge clk); #1; end
    end
    #1 reset = 1'b0; #1;
    got = observe(); exp = reset_model(Op); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_reset got=%h exp=%h", got, exp); end
    @(negedge clk); reset = 1'b1; #1;
    for (int unsigned k = 0; k < instr_len(Op, Funct); k++) begin
      got = observe(); exp = model(Op, Funct, Rd, k); checks++;
      if (got !== exp) begin errors++; $display("FAIL mid_post k=%0d got=%h exp=%h", k, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int unsigned n = 0; n < 80; n++) begin
      Op = 2'($urandom); Funct = 6'($urandom); Rd = 4'($urandom); #1;
      for (int unsigned k = 0; k < instr_len(Op, Funct); k++) begin
        got = observe(); exp = model(Op, Funct, Rd, k); checks++;
        if (got !== exp) begin
          errors++; $display("FAIL rand%0d op=%0d fn=%h k=%0d got=%h exp=%h", n, Op, Funct, k, got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_ldr();
    test_str();
    test_branch_pcs();
    test_alu_ops();
    test_reset_mid_instr();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
